// File: rtl/life_score_manager.sv
// Lives, BCD score and game-state controller for a frame-based arcade game.
// Every output is a register, so a triggering input shows up on the outputs one clock later.
module life_score_manager #(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter int unsigned FRUIT_POINTS  = 5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        SingleHitPulse,
  input  logic        fruitPulse,
  input  logic        startGame,
  output logic [1:0]  lives,
  output logic [11:0] score,
  output logic        freeze,
  output logic        gameOver,
  output logic        playing
);

  typedef enum logic [1:0] {StIdle, StPlay, StHitFreeze, StGameOver} state_e;

  state_e      state;
  logic [7:0]  frame_cnt;
  logic [11:0] score_add;
  logic [4:0]  units_raw, tens_raw, hund_raw;
  logic [3:0]  units_dig, tens_dig, hund_dig;
  logic        units_carry, tens_carry, hund_carry;

  // Decimal add of FRUIT_POINTS with ripple carry; a carry out of hundreds saturates at 999.
  always_comb begin
    units_raw   = {1'b0, score[3:0]} + 5'(FRUIT_POINTS);
    units_carry = units_raw > 5'd9;
    units_dig   = units_carry ? 4'(units_raw - 5'd10) : units_raw[3:0];
    tens_raw    = {1'b0, score[7:4]} + {4'b0, units_carry};
    tens_carry  = tens_raw > 5'd9;
    tens_dig    = tens_carry ? 4'(tens_raw - 5'd10) : tens_raw[3:0];
    hund_raw    = {1'b0, score[11:8]} + {4'b0, tens_carry};
    hund_carry  = hund_raw > 5'd9;
    hund_dig    = hund_carry ? 4'(hund_raw - 5'd10) : hund_raw[3:0];
    score_add   = hund_carry ? 12'h999 : {hund_dig, tens_dig, units_dig};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= StIdle;
      lives     <= 2'd0;
      score     <= 12'h000;
      frame_cnt <= 8'd0;
      freeze    <= 1'b0;
      gameOver  <= 1'b0;
      playing   <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StGameOver: begin
          if (startGame) begin
            state    <= StPlay;
            lives    <= 2'(INIT_LIVES);
            score    <= 12'h000;
            gameOver <= 1'b0;
            playing  <= 1'b1;
          end
        end
        StPlay: begin
          if (fruitPulse) score <= score_add;
          if (SingleHitPulse) begin
            playing <= 1'b0;
            if (lives > 2'd1) begin
              lives     <= lives - 2'd1;
              frame_cnt <= 8'(FREEZE_FRAMES);
              state     <= StHitFreeze;
              freeze    <= 1'b1;
            end else begin
              lives    <= 2'd0;
              state    <= StGameOver;
              gameOver <= 1'b1;
            end
          end
        end
        StHitFreeze: begin
          // Hits, fruit and start are all ignored here; only frame starts advance.
          if (startOfFrame && frame_cnt != 8'd0) begin
            frame_cnt <= frame_cnt - 8'd1;
            if (frame_cnt == 8'd1) begin
              state   <= StPlay;
              freeze  <= 1'b0;
              playing <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/life_score_manager.md
LIFE_SCORE_MANAGER -- requirements
Module: life_score_manager

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded at game start (legal range 1..3).
REQ-002 Parameter FREEZE_FRAMES, default 60, number of frames the game freezes after a non-fatal hit (legal range 1..255).
REQ-003 Parameter FRUIT_POINTS, default 5, BCD points added per fruit pickup (legal range 1..9).
REQ-004 clk  input  1  system clock; the single clock of the block.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 startOfFrame  input  1  one-clk pulse at each frame start (30 Hz).
REQ-007 SingleHitPulse  input  1  one-clk pulse, at most once per frame, for a player/enemy collision from the collision controller.
REQ-008 fruitPulse  input  1  one-clk pulse for a player/fruit collision.
REQ-009 startGame  input  1  one-clk pulse from the debounced start key.
REQ-010 lives  output  2  remaining lives.
REQ-011 score  output  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-012 freeze  output  1  high while in HIT_FREEZE; movers halt.
REQ-013 gameOver  output  1  high while in GAME_OVER.
REQ-014 playing  output  1  high while in PLAY.

Function
REQ-015 All outputs SHALL be registered and SHALL update on posedge clk, with 1-clk latency from the triggering input.
REQ-016 The FSM SHALL have four states: IDLE, PLAY, HIT_FREEZE, GAME_OVER.
REQ-017 IDLE: on startGame, go to PLAY, set lives=INIT_LIVES and score=0; all other inputs are ignored in IDLE.
REQ-018 PLAY, SingleHitPulse, lives>1: decrement lives, load the frame counter with FREEZE_FRAMES, go to HIT_FREEZE.
REQ-019 PLAY, SingleHitPulse, lives==1: set lives=0, go to GAME_OVER.
REQ-020 HIT_FREEZE: decrement the frame counter on each startOfFrame; when startOfFrame arrives with counter==1, go to PLAY (exactly FREEZE_FRAMES frame starts after entry).
REQ-021 HIT_FREEZE: SingleHitPulse and fruitPulse are ignored (invulnerability).
REQ-022 GAME_OVER: lives and score hold; on startGame, reload lives=INIT_LIVES, clear score, go to PLAY.
REQ-023 startGame in PLAY or HIT_FREEZE is ignored.
REQ-024 fruitPulse in PLAY adds FRUIT_POINTS to the units digit as decimal arithmetic: each digit is 0..9, a digit reaching ≥10 subtracts 10 and carries 1 to the next digit.
REQ-025 Score saturates at 999: an addition that would exceed 999 leaves score=999; no wrap-around.
REQ-026 SingleHitPulse and fruitPulse in the same PLAY cycle: apply both; the score update is taken and the hit transition is taken (including to GAME_OVER).
REQ-027 startOfFrame coincident with the state's entry cycle does not decrement the counter; counting begins on the next cycle.
REQ-028 The frame counter is 8 bits wide; it never underflows and is held when not in HIT_FREEZE.
REQ-029 freeze, gameOver and playing are mutually exclusive and are all low in IDLE.

Reset
REQ-030 resetN low SHALL, asynchronously and in any state (including mid-freeze), force: state=IDLE, lives=0, score=0, frame counter=0, freeze=0, gameOver=0, playing=0.
REQ-031 After resetN rises, the block SHALL wait in IDLE for startGame; no pending pulse is remembered across reset.

Verification
REQ-032 Reset, then startGame -> next clk: playing=1, lives=3, score=0x000.
REQ-033 PLAY, SingleHitPulse -> lives=2, freeze=1; after 60 startOfFrame pulses -> freeze=0, playing=1; SingleHitPulse during freeze -> lives stays 2.
REQ-034 Three hits, each separated by a full freeze -> lives 2, 1, then 0 with gameOver=1; then startGame -> lives=3, score=0x000, playing=1.
REQ-035 Score at 0x097, fruitPulse (FRUIT_POINTS=5) -> score=0x102; score at 0x996, fruitPulse -> score=0x999; another fruitPulse -> stays 0x999.
REQ-036 PLAY, lives=1, SingleHitPulse and fruitPulse in the same clk with score=0x010 -> score=0x015, lives=0, gameOver=1.
REQ-037 resetN asserted mid-HIT_FREEZE -> all outputs 0 immediately, without waiting for a clk edge; startOfFrame pulses after release -> state stays IDLE.
